// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester round-robin arbiter around a shared add/sub/and/or ALU
//
// Purpose:
//   Accepts one command at a time from two valid/ready request ports and
//   runs it through a single WIDTH-bit ALU. The result comes back on one
//   registered response channel, tagged with the id of the requester.
//   Only one operation is in flight at a time (IDLE -> EXEC -> RESP).
//
// Ports:
//   clk, rst                       rising-edge clock, async active-high reset
//   req0_valid/ready/a/b/op        requester 0 command port
//   req1_valid/ready/a/b/op        requester 1 command port
//   rsp_valid/ready                response handshake
//   rsp_id, rsp_data               issuing requester, ALU result
//   rsp_carry                      add carry-out / sub borrow / 0 for logic ops
//   rsp_zero                       rsp_data == 0
//   busy                           an operation is in progress
module alu_share_arbiter #(
  parameter int WIDTH     = 4,
  parameter bit INIT_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_next;
  logic             prio;
  logic             grant_any;
  logic             grant_id;
  logic             accept;
  logic [WIDTH-1:0] a_q, b_q;
  logic [1:0]       op_q;
  logic             id_q;
  logic [WIDTH:0]   wide;

  // A lone requester wins regardless of prio; prio only breaks ties.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = (req0_valid && req1_valid) ? prio : req1_valid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        req0_ready = !rst && grant_any && !grant_id;
        req1_ready = !rst && grant_any && grant_id;
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        if (accept) begin
          state_next = EXEC;
        end
      end
      EXEC: begin
        state_next = RESP;
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // One extra bit on the intermediate carries the add carry-out, or the
  // borrow for subtraction (it is set exactly when a < b).
  always_comb begin
    wide = '0;
    case (op_q)
      2'b00:   wide = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   wide = {1'b0, a_q} - {1'b0, b_q};
      2'b10:   wide = {1'b0, a_q & b_q};
      2'b11:   wide = {1'b0, a_q | b_q};
      default: wide = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio      <= INIT_PRIO;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 2'b00;
      id_q      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_data  <= '0;
      rsp_carry <= 1'b0;
      rsp_zero  <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= grant_id ? req1_a  : req0_a;
        b_q  <= grant_id ? req1_b  : req0_b;
        op_q <= grant_id ? req1_op : req0_op;
        id_q <= grant_id;
      end
      if (state == EXEC) begin
        rsp_valid <= 1'b1;
        rsp_id    <= id_q;
        rsp_data  <= wide[WIDTH-1:0];
        rsp_carry <= wide[WIDTH];
        rsp_zero  <= (wide[WIDTH-1:0] == '0);
      end
      if (state == RESP && rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        // The port just served drops to lower priority.
        prio      <= ~rsp_id;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0;
  logic       req0_ready;
  logic [3:0] req0_a = 4'd0;
  logic [3:0] req0_b = 4'd0;
  logic [1:0] req0_op = 2'd0;
  logic       req1_valid = 1'b0;
  logic       req1_ready;
  logic [3:0] req1_a = 4'd0;
  logic [3:0] req1_b = 4'd0;
  logic [1:0] req1_op = 2'd0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic       rsp_id;
  logic [3:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_zero;
  logic       busy;

  int vectors     = 0;
  int miscompares = 0;

  alu_share_arbiter #(.WIDTH(4), .INIT_PRIO(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; sample and drive 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single-requester operation with rsp_ready held high.
  task automatic single_op(input logic port, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic [3:0] exp_data,
                           input logic exp_carry, input logic exp_zero);
    if (port) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
    #1;
    chk("ready_granted", {req1_ready, req0_ready}, port ? 8'd2 : 8'd1);
    tick();
    // Scramble the port after the handshake; latched operands must win.
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = 4'hF; req0_b = 4'h0; req0_op = 2'b11;
    req1_a = 4'hF; req1_b = 4'h0; req1_op = 2'b11;
    chk("exec_busy", busy, 8'd1);
    chk("exec_rsp_valid", rsp_valid, 8'd0);
    tick();
    chk("rsp_valid", rsp_valid, 8'd1);
    chk("rsp_id", rsp_id, port);
    chk("rsp_data", rsp_data, exp_data);
    chk("rsp_carry", rsp_carry, exp_carry);
    chk("rsp_zero", rsp_zero, exp_zero);
    tick();
    chk("rsp_done", rsp_valid, 8'd0);
    chk("idle_busy", busy, 8'd0);
  endtask

  initial begin
    // Reset state; ready must stay low while rst is high even with a request.
    req0_valid = 1'b1;
    #2;
    chk("rst_ready0", req0_ready, 8'd0);
    chk("rst_rsp_valid", rsp_valid, 8'd0);
    chk("rst_busy", busy, 8'd0);
    chk("rst_rsp_data", rsp_data, 8'd0);
    req0_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    single_op(1'b0, 4'd5, 4'd3, 2'b01, 4'd2,  1'b0, 1'b0);
    single_op(1'b1, 4'd3, 4'd5, 2'b01, 4'd14, 1'b1, 1'b0);
    single_op(1'b0, 4'd5, 4'd3, 2'b10, 4'd1,  1'b0, 1'b0);
    single_op(1'b0, 4'd5, 4'd3, 2'b11, 4'd7,  1'b0, 1'b0);
    single_op(1'b1, 4'd5, 4'd5, 2'b01, 4'd0,  1'b0, 1'b1);
    single_op(1'b0, 4'd9, 4'd9, 2'b00, 4'd2,  1'b1, 1'b0);

    // Last served was requester 0, so prio now names requester 1. Serve
    // requester 1 once more to bring prio back to 0 before the contention run.
    single_op(1'b1, 4'd6, 4'd1, 2'b00, 4'd7,  1'b0, 1'b0);

    // Both valid continuously: ids alternate 0,1,0,1, three cycles each.
    req0_valid = 1'b1; req0_a = 4'd12; req0_b = 4'd7; req0_op = 2'b00;
    req1_valid = 1'b1; req1_a = 4'd12; req1_b = 4'd7; req1_op = 2'b01;
    for (int k = 0; k < 4; k++) begin
      #0;
      chk("rr_ready", {req1_ready, req0_ready}, (k % 2) ? 8'd2 : 8'd1);
      tick();
      tick();
      chk("rr_valid", rsp_valid, 8'd1);
      chk("rr_id", rsp_id, (k % 2) ? 8'd1 : 8'd0);
      chk("rr_data", rsp_data, (k % 2) ? 8'd5 : 8'd3);
      chk("rr_carry", rsp_carry, (k % 2) ? 8'd0 : 8'd1);
      tick();
    end

    // Backpressure: response held for 5 cycles, no new accept.
    rsp_ready = 1'b0;
    tick();
    tick();
    chk("bp_valid", rsp_valid, 8'd1);
    chk("bp_id", rsp_id, 8'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_hold_valid", rsp_valid, 8'd1);
      chk("bp_hold_data", rsp_data, 8'd3);
      chk("bp_hold_id", rsp_id, 8'd0);
      chk("bp_hold_carry", rsp_carry, 8'd1);
      chk("bp_no_ready", {req1_ready, req0_ready}, 8'd0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_released", rsp_valid, 8'd0);
    chk("bp_next_grant", {req1_ready, req0_ready}, 8'd2);

    // Reset while in RESP: rsp_valid falls with no clock edge; prio back to 0.
    rsp_ready = 1'b0;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("pre_rst_valid", rsp_valid, 8'd1);
    chk("pre_rst_id", rsp_id, 8'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", rsp_valid, 8'd0);
    chk("async_rst_busy", busy, 8'd0);
    chk("async_rst_id", rsp_id, 8'd0);
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("post_rst_prio", {req1_ready, req0_ready}, 8'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
    chk("post_rst_id", rsp_id, 8'd0);
    chk("post_rst_data", rsp_data, 8'd3);
    tick();
    chk("post_rst_done", rsp_valid, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
